imem_loader: RTL
================

# imem_loader

Program loader that writes the 37-bit instruction memory from a byte stream, which is the write side of the instruction fetch port. It accepts bytes over a valid/ready handshake and assembles them little-endian into 37-bit instruction words. It writes those words to sequential 10-bit instruction addresses starting at 0. It holds the CPU in reset until a load completes, so the CPU begins fetching at PC 0 only after the program is fully resident.

## Interface
- INSTR_WIDTH, 37, instruction word width
- ADDR_WIDTH, 10, instruction memory address width (1024 words)
- BYTES_PER_WORD, 5, bytes per instruction word (ceil(INSTR_WIDTH/8))

- clk  in  1  clock; all state changes on rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  single-cycle request to begin a load; sampled only in IDLE
- word_count  in  ADDR_WIDTH+1  number of instructions to load; sampled with start
- in_valid  in  1  byte stream valid
- in_data  in  8  byte stream data
- in_ready  out  1  loader accepts a byte this cycle
- imem_we  out  1  instruction memory write strobe, one cycle per word
- imem_addr  out  ADDR_WIDTH  write address
- imem_wdata  out  INSTR_WIDTH  write data
- cpu_hold  out  1  high = CPU must be held in reset
- busy  out  1  high in LOAD and WRITE
- done  out  1  one-cycle pulse when a load finishes
- error  out  1  sticky format error for the current load

## Operation
- States: IDLE, LOAD, WRITE, DONE.
- Reset values: state IDLE; in_ready 0, imem_we 0, imem_addr 0, imem_wdata 0, cpu_hold 1, busy 0, done 0, error 0; internal byte index 0, word counter 0, assembly register 0.
- IDLE to LOAD on start when word_count is nonzero. This clears error, sets imem_addr to 0, loads words_left = min(word_count, 1024), sets byte_idx to 0, and sets cpu_hold to 1.
- IDLE to DONE on start when word_count is 0. No writes occur.
- start is ignored in LOAD, WRITE and DONE.
- LOAD: in_ready = 1. A byte is accepted when in_valid and in_ready are both high.
  - Byte k (k = 0..4) fills assembly bits [8k+7:8k].
  - Byte 4 supplies bits [36:32] from in_data[4:0]. If in_data[7:5] is nonzero, error is set and the truncated word is still written.
  - Acceptance of byte 4 moves the block to WRITE. Otherwise byte_idx increments.
- WRITE: in_ready = 0 and imem_we = 1 for exactly one cycle, with imem_addr and imem_wdata equal to the assembled word.
  - On exit, imem_addr increments by 1 and words_left decrements by 1.
  - If words_left reaches 0, go to DONE. Otherwise go to LOAD with byte_idx = 0.
- DONE: done = 1 for one cycle and cpu_hold goes to 0 in the same cycle. Next state is IDLE.
- cpu_hold stays 0 in IDLE until the next accepted start.
- Address wrap: a 1024-word load ends with its final write at address 1023. The incremented address wraps to 0, but no further write occurs.
- Reset asserted at any point returns every output to its reset value immediately (asynchronous). A partial word is discarded and not written.
- in_valid is ignored whenever in_ready is 0. Bytes presented then are not consumed.

## Timing
- in_ready, imem_we, busy, done and cpu_hold are registered outputs or decoded from the registered state. None depends combinationally on in_valid.
- start accepted at cycle T: the block is in LOAD at T+1 (in_ready = 1 at T+1).
- Byte 4 accepted at cycle N: imem_we = 1 at N+1. The next byte can be accepted at N+2 at the earliest.
- Peak throughput is 6 cycles per word. A K-word load with continuous in_valid takes start to done = 6K+1 cycles.
- Last write at cycle W: done = 1 and cpu_hold = 0 at W+1, and the block is in IDLE at W+2.
- word_count = 0 with start at T: done = 1 at T+1.
- A start coincident with done (in the DONE cycle) is ignored.

## Test plan
- Reset: assert reset mid-cycle -> all outputs immediately at reset values, with cpu_hold = 1 and in_ready = 0.
- Two-word load: word_count = 2 with bytes 0x11 0x22 0x33 0x44 0x05 and 0xAA 0xBB 0xCC 0xDD 0x1F at full rate.
  - Expect writes addr 0 = 0x05_4433_2211 and addr 1 = 0x1F_DDCC_BBAA, exactly two imem_we pulses.
  - Expect done at cycle 13 after start, then cpu_hold = 0.
- Backpressure and gaps: random in_valid gaps during a 3-word load -> identical written data. Bytes presented during WRITE are held, not dropped.
- Zero count: start with word_count = 0 -> done = 1 the next cycle, no imem_we, cpu_hold = 0.
- Format error: byte 4 = 0xE1 -> error = 1 sticky through done, imem_wdata[36:32] = 0x01. The next start clears error.
- Reset mid-load and start while busy: after 3 of 5 bytes assert reset -> no imem_we, cpu_hold = 1. A start pulse during LOAD of a new 1-word load does not restart it: imem_addr stays 0 and words_left is unchanged.

Source files
------------

// File: rtl/imem_loader.sv
// imem_loader: loads little-endian byte stream into instruction memory words, holding the CPU in reset until done
module imem_loader #(
    parameter int INSTR_WIDTH    = 37,
    parameter int ADDR_WIDTH     = 10,
    parameter int BYTES_PER_WORD = 5
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   start_i,
    input  logic [ADDR_WIDTH:0]    word_count_i,
    input  logic                   in_valid_i,
    input  logic [7:0]             in_data_i,
    output logic                   in_ready_o,
    output logic                   imem_we_o,
    output logic [ADDR_WIDTH-1:0]  imem_addr_o,
    output logic [INSTR_WIDTH-1:0] imem_wdata_o,
    output logic                   cpu_hold_o,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   error_o
);
    localparam int IDX_W = $clog2(BYTES_PER_WORD);
    localparam int LAST_BITS = INSTR_WIDTH - 8 * (BYTES_PER_WORD - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES_PER_WORD - 1);
    localparam logic [ADDR_WIDTH:0] MAX_WORDS = {1'b1, {ADDR_WIDTH{1'b0}}};

    typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} state_t;

    state_t                 state_q, state_d;
    logic [IDX_W-1:0]       byte_idx_q, byte_idx_d;
    logic [ADDR_WIDTH:0]    words_left_q, words_left_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [INSTR_WIDTH-1:0] asm_q, asm_d;
    logic                   hold_q, hold_d;
    logic                   err_q, err_d;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q      <= IDLE;
            byte_idx_q   <= '0;
            words_left_q <= '0;
            addr_q       <= '0;
            asm_q        <= '0;
            hold_q       <= 1'b1;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            byte_idx_q   <= byte_idx_d;
            words_left_q <= words_left_d;
            addr_q       <= addr_d;
            asm_q        <= asm_d;
            hold_q       <= hold_d;
            err_q        <= err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        byte_idx_d   = byte_idx_q;
        words_left_d = words_left_q;
        addr_d       = addr_q;
        asm_d        = asm_q;
        hold_d       = hold_q;
        err_d        = err_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    err_d = 1'b0;
                    if (word_count_i == '0) begin
                        state_d = DONE;
                        hold_d  = 1'b0;
                    end else begin
                        state_d      = LOAD;
                        addr_d       = '0;
                        words_left_d = (word_count_i > MAX_WORDS) ? MAX_WORDS : word_count_i;
                        byte_idx_d   = '0;
                        hold_d       = 1'b1;
                    end
                end
            end
            LOAD: begin
                if (in_valid_i) begin
                    for (int k = 0; k < BYTES_PER_WORD - 1; k++)
                        if (int'(byte_idx_q) == k) asm_d[8*k +: 8] = in_data_i;
                    if (byte_idx_q == LAST_IDX) begin
                        // top byte only carries the word's remaining bits; any higher bit set is a format error
                        asm_d[INSTR_WIDTH-1 -: LAST_BITS] = in_data_i[LAST_BITS-1:0];
                        err_d   = err_q | (|(in_data_i >> LAST_BITS));
                        state_d = WRITE;
                    end else begin
                        byte_idx_d = byte_idx_q + IDX_W'(1);
                    end
                end
            end
            WRITE: begin
                addr_d       = addr_q + ADDR_WIDTH'(1);
                words_left_d = words_left_q - (ADDR_WIDTH+1)'(1);
                byte_idx_d   = '0;
                if (words_left_q == (ADDR_WIDTH+1)'(1)) begin
                    state_d = DONE;
                    hold_d  = 1'b0;
                end else begin
                    state_d = LOAD;
                end
            end
            DONE: state_d = IDLE;
        endcase
    end

    assign in_ready_o   = state_q == LOAD;
    assign imem_we_o    = state_q == WRITE;
    assign busy_o       = state_q == LOAD || state_q == WRITE;
    assign done_o       = state_q == DONE;
    assign imem_addr_o  = addr_q;
    assign imem_wdata_o = asm_q;
    assign cpu_hold_o   = hold_q;
    assign error_o      = err_q;
endmodule
